hvsync_generator: RTL and testbench
===================================

HVSYNC_GENERATOR -- requirements
Module: hvsync_generator

Interface
REQ-001 SHALL have exactly one clock and one reset: clk is the single clock; rst_n is the asynchronous, active-low reset.
REQ-002 Ports SHALL be, in this order:
- clk  input  1  pixel clock, nominal 25 MHz; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- hsync  output  1  horizontal sync, active low.
- vsync  output  1  vertical sync, active low.
- display_on  output  1  high while (hpos, vpos) lies in the visible area.
- hpos  output  10  current pixel column, 0..799.
- vpos  output  10  current line, 0..524.
REQ-003 Parameters SHALL be as follows (name, default, meaning), giving 640x480@60 timing:
- H_DISPLAY, 640, visible columns.
- H_FRONT, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BACK, 48, horizontal back porch.
- V_DISPLAY, 480, visible lines.
- V_BOTTOM, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_TOP, 33, vertical back porch.

Function
REQ-004 Derived constants SHALL be:
- H_TOTAL = sum of the H parameters = 800.
- V_TOTAL = sum of the V parameters = 525.
- H_SYNC_START = H_DISPLAY+H_FRONT = 656; H_SYNC_END = H_SYNC_START+H_SYNC-1 = 751.
- V_SYNC_START = V_DISPLAY+V_BOTTOM = 490; V_SYNC_END = 491.
REQ-005 hpos SHALL increment by 1 every clk cycle; from H_TOTAL-1 (799) it SHALL wrap to 0 on the next cycle.
REQ-006 vpos SHALL increment by 1 only in the cycle where hpos wraps from 799 to 0; from V_TOTAL-1 (524) it SHALL wrap to 0 on that same wrap.
REQ-007 Simultaneous wrap: at (hpos=799, vpos=524) the next cycle SHALL show (0, 0).
REQ-008 hpos and vpos SHALL be registered counters; no other values are legal, and they SHALL never exceed 799 and 524 respectively.
REQ-009 hsync SHALL be registered and low exactly in cycles where the presented hpos is in 656..751 inclusive (96 clocks per line), high otherwise; it SHALL be aligned to hpos with no lag, so the register is loaded from the next-state hpos.
REQ-010 vsync SHALL be registered and low for all 800 cycles of every line whose presented vpos is 490 or 491 (1600 clocks per frame), high otherwise; it SHALL be aligned to vpos with no lag.
REQ-011 display_on SHALL equal (hpos < 640) AND (vpos < 480), combinational from the counter registers.
REQ-012 The frame period SHALL be exactly 420000 clk cycles; there is no enable input and no stall.

Reset
REQ-013 While rst_n=0, the outputs SHALL be hpos=0, vpos=0, hsync=1, vsync=1 and display_on=1, asynchronously on assertion.
REQ-014 After rst_n deasserts, the first rising clk SHALL advance hpos to 1.
REQ-015 Assertion mid-frame SHALL abort the frame immediately, and counting SHALL restart from (0, 0) with no partial-frame state retained.

Structure
REQ-016 A shared package vga_timing_pkg SHALL hold the eight timing defaults, the derived totals and sync start/end values, and the 10-bit coordinate width.
REQ-017 Two instances of one sub-module, sync_counter, SHALL be used:
- sync_counter is a wrapping counter with parameters TOTAL, SYNC_START and SYNC_END, an advance enable, a wrap output and a registered active-low sync output.
- The horizontal instance SHALL be enabled every cycle.
- The vertical instance SHALL be enabled by the horizontal wrap.

Verification
REQ-018 Reset release then 800 clocks -> hpos runs 0..799 and returns to 0, and vpos steps from 0 to 1 exactly at that wrap.
REQ-019 Count hsync-low clocks over one line -> 96, with the first low cycle at hpos=656 and the last at 751.
REQ-020 Run a full frame of 420000 clocks:
- vsync low for exactly 1600 clocks, starting at (hpos 0, vpos 490).
- After the frame, hpos and vpos are back at (0, 0).
REQ-021 Sample display_on at (639,479), (640,0), (0,480) and (0,0) -> 1, 0, 0, 1; the total display_on-high count per frame is 307200.
REQ-022 Pulse rst_n low for 3 ns at (hpos 300, vpos 200), asynchronous to clk -> hpos=0, vpos=0 and syncs high immediately, then normal counting resumes.
REQ-023 Corner at (799, 524) -> the next clock gives (0, 0) with display_on=1, hsync=1 and vsync=1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing defaults, derived totals and coordinate type.
// Imported by the sync generator top and its per-axis counter.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    // Horizontal timing, in pixel clocks.
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;

    // Vertical timing, in lines.
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_BOTTOM  = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_TOP     = 33;

    localparam int DEF_H_TOTAL      = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL      = DEF_V_DISPLAY + DEF_V_BOTTOM + DEF_V_SYNC + DEF_V_TOP;
    localparam int DEF_H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
    localparam int DEF_V_SYNC_START = DEF_V_DISPLAY + DEF_V_BOTTOM;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

    // True when a coordinate lies inside the inclusive window [lo, hi].
    function automatic logic in_window(input coord_t value, input int lo, input int hi);
        return (int'(value) >= lo) && (int'(value) <= hi);
    endfunction

endpackage

// File: rtl/sync_counter.sv
// One axis of the raster: a wrapping position counter plus an active-low
// sync pulse registered from the next count so it lines up with the count.
module sync_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = DEF_H_TOTAL,
    parameter int SYNC_START = DEF_H_SYNC_START,
    parameter int SYNC_END   = DEF_H_SYNC_END
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    output coord_t count,
    output logic   wrap,
    output logic   sync_n
);

    logic   at_last;
    coord_t count_next;

    assign at_last = (count == coord_t'(TOTAL - 1));
    assign wrap    = en && at_last;

    always_comb begin
        count_next = count;
        if (en) begin
            count_next = at_last ? '0 : count + coord_t'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            sync_n <= 1'b1;
        end else begin
            count  <= count_next;
            // Loaded from the next count so the pulse has no lag vs. count.
            sync_n <= !in_window(count_next, SYNC_START, SYNC_END);
        end
    end

endmodule

// File: rtl/hvsync_generator.sv
// VGA raster timing generator: horizontal and vertical sync_counter instances
// chained by the line wrap, plus the visible-area flag.
module hvsync_generator
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_BOTTOM  = DEF_V_BOTTOM,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_TOP     = DEF_V_TOP
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic [COORD_W-1:0] hpos,
    output logic [COORD_W-1:0] vpos
);

    localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    logic h_wrap;
    logic v_wrap;

    sync_counter #(
        .TOTAL      (H_TOTAL),
        .SYNC_START (H_SYNC_START),
        .SYNC_END   (H_SYNC_END)
    ) u_h_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (1'b1),
        .count  (hpos),
        .wrap   (h_wrap),
        .sync_n (hsync)
    );

    // Lines advance only on the pixel-counter wrap.
    sync_counter #(
        .TOTAL      (V_TOTAL),
        .SYNC_START (V_SYNC_START),
        .SYNC_END   (V_SYNC_END)
    ) u_v_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (h_wrap),
        .count  (vpos),
        .wrap   (v_wrap),
        .sync_n (vsync)
    );

    assign display_on = (hpos < coord_t'(H_DISPLAY)) && (vpos < coord_t'(V_DISPLAY));

    // A frame wrap always lands on the raster origin.
    frame_wrap_to_origin: assert property (
        @(posedge clk) disable iff (!rst_n) v_wrap |=> (hpos == '0 && vpos == '0)
    );

endmodule

// File: tb/tb_hvsync_generator.sv
// Scoreboard bench for hvsync_generator: an independent raster model queues
// the expected outputs on each rising edge; they are compared on falling edges.
module tb_hvsync_generator;

    localparam int FRAME_CLKS = 420000;

    logic       clk;
    logic       rst_n;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic [9:0] hpos;
    logic [9:0] vpos;

    hvsync_generator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hsync      (hsync),
        .vsync      (vsync),
        .display_on (display_on),
        .hpos       (hpos),
        .vpos       (vpos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected packed view: {hpos, vpos, hsync, vsync, display_on}.
    function automatic logic [31:0] expect_of(input int h, input int v);
        logic hs, vs, de;
        hs = !(h >= 656 && h <= 751);
        vs = !(v >= 490 && v <= 491);
        de = (h < 640) && (v < 480);
        return {9'd0, 10'(h), 10'(v), hs, vs, de};
    endfunction

    function automatic logic [31:0] observed();
        return {9'd0, hpos, vpos, hsync, vsync, display_on};
    endfunction

    int            m_h = 0;
    int            m_v = 0;
    logic [31:0]   sb_q[$];
    logic          running = 1'b0;
    logic          frame_en = 1'b0;

    int de_cnt = 0;
    int vs_low_cnt = 0;
    int vs_first_h = -1;
    int vs_first_v = -1;
    int hs_low_cnt = 0;
    int hs_first_h = -1;
    int hs_last_h = -1;

    // Raster model: advances on every clock out of reset.
    always @(posedge clk) begin
        if (rst_n && running) begin
            if (m_h == 799) begin
                m_h = 0;
                m_v = (m_v == 524) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
            sb_q.push_back(expect_of(m_h, m_v));
        end
    end

    // Full-cycle comparison only in windows that hold the interesting lines.
    function automatic logic watch(input int v);
        return (v <= 1) || (v == 479) || (v >= 489 && v <= 492) || (v == 524);
    endfunction

    always @(negedge clk) begin
        logic [31:0] exp_v;
        if (rst_n && running) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                exp_v = sb_q.pop_front();
                if (watch(m_v)) check("cycle", observed(), exp_v);
            end
            if (frame_en) begin
                if (display_on) de_cnt++;
                if (!vsync) begin
                    if (vs_low_cnt == 0) begin
                        vs_first_h = int'(hpos);
                        vs_first_v = int'(vpos);
                    end
                    vs_low_cnt++;
                end
                if (m_v == 0 && !hsync) begin
                    if (hs_low_cnt == 0) hs_first_h = int'(hpos);
                    hs_last_h = int'(hpos);
                    hs_low_cnt++;
                end
                if (m_h == 639 && m_v == 479) check("de_639_479", 32'(display_on), 32'd1);
                if (m_h == 640 && m_v == 0)   check("de_640_0", 32'(display_on), 32'd0);
                if (m_h == 0 && m_v == 480)   check("de_0_480", 32'(display_on), 32'd0);
                if (m_h == 0 && m_v == 1)     check("vpos_step_at_wrap", 32'(vpos), 32'd1);
                if (m_h == 0 && m_v == 0)     check("corner_to_origin", observed(), expect_of(0, 0));
            end
        end
    end

    initial begin
        logic found;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("reset_async", observed(), expect_of(0, 0));
        #5;
        check("reset_held", observed(), expect_of(0, 0));
        #4;
        // t=12: release between the falling edge at 10 and the rising edge at 15.
        running  = 1'b1;
        frame_en = 1'b1;
        rst_n    = 1'b1;
        @(negedge clk);
        check("first_clk_hpos", 32'(hpos), 32'd1);
        for (int i = 1; i < FRAME_CLKS; i++) @(negedge clk);
        #1 frame_en = 1'b0;

        check("frame_end_hpos", 32'(hpos), 32'd0);
        check("frame_end_vpos", 32'(vpos), 32'd0);
        check("hs_low_per_line", 32'(hs_low_cnt), 32'd96);
        check("hs_first_low", 32'(hs_first_h), 32'd656);
        check("hs_last_low", 32'(hs_last_h), 32'd751);
        check("vs_low_per_frame", 32'(vs_low_cnt), 32'd1600);
        check("vs_first_low_h", 32'(vs_first_h), 32'd0);
        check("vs_first_low_v", 32'(vs_first_v), 32'd490);
        check("de_per_frame", 32'(de_cnt), 32'd307200);

        // Mid-frame asynchronous reset pulse at (300, 200).
        found = 1'b0;
        for (int i = 0; i < FRAME_CLKS && !found; i++) begin
            @(negedge clk);
            if (m_h == 300 && m_v == 200) found = 1'b1;
        end
        check("reach_300_200", 32'(found), 32'd1);
        if (found) begin
            check("pre_pulse", observed(), expect_of(300, 200));
            #1 rst_n = 1'b0;
            #1;
            check("pulse_async", observed(), expect_of(0, 0));
            m_h = 0;
            m_v = 0;
            sb_q.delete();
            #2 rst_n = 1'b1;
            @(negedge clk);
            check("resume_hpos", observed(), expect_of(1, 0));
            for (int i = 0; i < 1000; i++) @(negedge clk);
            check("resume_run", observed(), expect_of(201, 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
